// File: rtl/chu_gpi_dbnc_if.sv
// Standard MMIO slot bus between the MMIO controller (master) and a slot core (slave).
interface chu_gpi_dbnc_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/chu_gpi_dbnc.sv
// Debounced GPI slot core: per-bit 2-FF sync and debounce, sticky W1C
// rise/fall event registers and a maskable level interrupt.
module chu_gpi_dbnc #(
    parameter int W         = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    chu_gpi_dbnc_if.slave  bus,
    input  logic [W-1:0]   din,
    output logic           irq
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [W-1:0]  s1, s2, db, db_d;
    logic [CW-1:0] cnt [W];
    logic [W-1:0]  rise, fall, ie;
    logic [W-1:0]  rise_set, fall_set, rise_clr, fall_clr;
    logic          wr_en;
    logic          unused_bus;

    assign wr_en      = bus.cs & bus.write;
    assign unused_bus = &{1'b0, bus.read, bus.wr_data};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_d <= '0;
            for (int unsigned i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            db_d <= db;
            for (int unsigned i = 0; i < W; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise_set = db & ~db_d;
    assign fall_set = ~db & db_d;

    always_comb begin
        rise_clr = '0;
        fall_clr = '0;
        if (wr_en && bus.addr == 5'd1) rise_clr = bus.wr_data[W-1:0];
        if (wr_en && bus.addr == 5'd2) fall_clr = bus.wr_data[W-1:0];
    end

    // Set is OR-ed in after the clear so a same-edge event survives a W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise <= '0;
            fall <= '0;
            ie   <= '0;
        end else begin
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
            if (wr_en && bus.addr == 5'd3) ie <= bus.wr_data[W-1:0];
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            5'd0:    bus.rd_data = 32'(db);
            5'd1:    bus.rd_data = 32'(rise);
            5'd2:    bus.rd_data = 32'(fall);
            5'd3:    bus.rd_data = 32'(ie);
            default: bus.rd_data = '0;
        endcase
    end

    assign irq = |((rise | fall) & ie);

endmodule
